// File: rtl/mac_pipe.sv
// mac_pipe: three-stage pipelined unsigned multiply-accumulate.
//   Accepts one operand pair per clock (no backpressure) and accumulates a*b
//   into a framed dot product. The frame is delimited by first/last.
//   Overflow either wraps modulo 2^ACC_W (SAT=0) or clamps at all-ones (SAT=1).
//   Either way the sticky ovf flag is set.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid this cycle
//   a, b       unsigned operands, WIDTH bits
//   first      (with in_valid) sample starts a new accumulation
//   last       (with in_valid) sample ends the accumulation
//   acc        running accumulator, ACC_W bits
//   out_valid  one-cycle pulse: acc holds a completed result
//   ovf        sticky overflow for the current accumulation
//   cnt        samples in the current accumulation (saturating)
module mac_pipe #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40,
  parameter int SAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             first,
  input  logic             last,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  // Resolve an ACC_W+1 bit sum into the stored accumulator value.
  function automatic logic [ACC_W-1:0] acc_resolve(input logic [ACC_W:0] s);
    if (s[ACC_W] && (SAT != 0)) return '1;
    return s[ACC_W-1:0];
  endfunction

  // Sample counter increment that sticks at its maximum.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  logic                 vld_p0_q, first_p0_q, last_p0_q;
  logic [WIDTH-1:0]     a_p0_q, b_p0_q;
  logic                 vld_p1_q, first_p1_q, last_p1_q;
  logic [2*WIDTH-1:0]   prod_p1_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q;
  logic [ACC_W:0]       base_d, sum_d;

  // S0: capture inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q   <= 1'b0;
      first_p0_q <= 1'b0;
      last_p0_q  <= 1'b0;
      a_p0_q     <= '0;
      b_p0_q     <= '0;
    end else begin
      vld_p0_q   <= in_valid;
      first_p0_q <= first & in_valid;
      last_p0_q  <= last & in_valid;
      a_p0_q     <= a;
      b_p0_q     <= b;
    end
  end

  // S1: full-precision multiply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      prod_p1_q  <= '0;
    end else begin
      vld_p1_q   <= vld_p0_q;
      first_p1_q <= first_p0_q;
      last_p1_q  <= last_p0_q;
      prod_p1_q  <= a_p0_q * b_p0_q;
    end
  end

  // S2: accumulate
  always_comb begin
    base_d = first_p1_q ? '0 : {1'b0, acc_q};
    sum_d  = base_d + {{(ACC_W + 1 - 2 * WIDTH){1'b0}}, prod_p1_q};
    acc_d  = acc_resolve(sum_d);
    // A first sample restarts the sticky flag from its own overflow.
    ovf_d  = sum_d[ACC_W] | (ovf_q & ~first_p1_q);
    cnt_d  = first_p1_q ? CNT_W'(1) : cnt_sat_inc(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (vld_p1_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
        cnt_q <= cnt_d;
      end
      out_valid_q <= vld_p1_q & last_p1_q;
    end
  end

  assign acc       = acc_q;
  assign ovf       = ovf_q;
  assign cnt       = cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: default configuration plus 32-bit wrap and
// 32-bit saturate instances driven by the same operand stream.
module tb_mac_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        first = 1'b0, last = 1'b0;

  logic [39:0] acc0;  logic ov0, ovf0;  logic [15:0] cnt0;
  logic [31:0] acc1;  logic ov1, ovf1;  logic [15:0] cnt1;
  logic [31:0] acc2;  logic ov2, ovf2;  logic [15:0] cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mac_pipe u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .first(first), .last(last),
    .acc(acc0), .out_valid(ov0), .ovf(ovf0), .cnt(cnt0));

  mac_pipe #(.WIDTH(16), .ACC_W(32), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .first(first), .last(last),
    .acc(acc1), .out_valid(ov1), .ovf(ovf1), .cnt(cnt1));

  mac_pipe #(.WIDTH(16), .ACC_W(32), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .first(first), .last(last),
    .acc(acc2), .out_valid(ov2), .ovf(ovf2), .cnt(cnt2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Present one input for one clock edge; returns 1 time unit after the edge.
  task automatic push(input logic v, input logic [15:0] av, input logic [15:0] bv,
                      input logic f, input logic l);
    in_valid = v; a = av; b = bv; first = f; last = l;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc0, 0);
    chk("rst_ovld", ov0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_cnt", cnt0, 0);
    rst = 1'b0;
    idle(1);

    // Four-sample frame; last sample at push 4, result two edges later
    push(1, 38, 61, 1, 0);
    push(1, 255, 255, 0, 0);
    push(1, 58, 381, 0, 0);
    push(1, 88, 61, 0, 1);
    idle(1);
    chk("f1_early_ovld", ov0, 0);
    idle(1);
    chk("f1_ovld", ov0, 1);
    chk("f1_acc", acc0, 94809);
    chk("f1_cnt", cnt0, 4);
    chk("f1_ovf", ovf0, 0);
    idle(1);
    chk("f1_pulse_end", ov0, 0);
    chk("f1_hold", acc0, 94809);

    // Continue without first onto the held result
    push(1, 6109, 4589, 0, 1);
    idle(1);
    chk("f2_early_ovld", ov0, 0);
    idle(1);
    chk("f2_ovld", ov0, 1);
    chk("f2_acc", acc0, 28129010);
    chk("f2_cnt", cnt0, 5);

    // Single-sample frame with bubbles around it; a stray first/last
    // without in_valid must be ignored.
    push(0, 0, 0, 0, 0);
    push(1, 6109, 4589, 1, 1);
    push(0, 7, 7, 1, 1);
    chk("bub_acc_pre", acc0, 28129010);
    push(0, 0, 0, 0, 0);
    chk("bub_ovld", ov0, 1);
    chk("bub_acc", acc0, 28034201);
    chk("bub_cnt", cnt0, 1);
    idle(3);
    chk("bub_ovld_after", ov0, 0);
    chk("bub_acc_after", acc0, 28034201);
    chk("bub_cnt_after", cnt0, 1);

    // Back-to-back one-sample frames
    push(1, 2, 2, 1, 1);
    push(1, 3, 3, 1, 1);
    idle(1);
    chk("b2b_ovld1", ov0, 1);
    chk("b2b_acc1", acc0, 4);
    idle(1);
    chk("b2b_ovld2", ov0, 1);
    chk("b2b_acc2", acc0, 9);
    idle(1);
    chk("b2b_ovld3", ov0, 0);

    // 32-bit accumulator overflow: wrap vs saturate
    push(1, 65535, 65535, 1, 0);
    push(1, 65535, 65535, 0, 1);
    idle(2);
    chk("wrap_ovld", ov1, 1);
    chk("wrap_acc", acc1, 64'd4294705154);
    chk("wrap_ovf", ovf1, 1);
    chk("sat_ovld", ov2, 1);
    chk("sat_acc", acc2, 64'd4294967295);
    chk("sat_ovf", ovf2, 1);
    push(1, 1, 1, 0, 0);
    idle(2);
    chk("sat_hold_acc", acc2, 64'd4294967295);
    chk("sat_hold_ovf", ovf2, 1);
    chk("sat_hold_cnt", cnt2, 3);
    chk("sat_no_ovld", ov2, 0);
    chk("wrap_cont_acc", acc1, 64'd4294705155);
    push(1, 2, 3, 1, 1);
    idle(2);
    chk("wrap_new_acc", acc1, 6);
    chk("wrap_new_ovf", ovf1, 0);
    chk("sat_new_acc", acc2, 6);
    chk("sat_new_ovf", ovf2, 0);

    // Asynchronous reset with two samples in flight
    push(1, 10, 10, 1, 0);
    push(1, 20, 20, 0, 1);
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", acc0, 0);
    chk("arst_cnt", cnt0, 0);
    chk("arst_ovf", ovf0, 0);
    chk("arst_ovld", ov0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    chk("arst_no_ovld1", ov0, 0);
    idle(1);
    chk("arst_no_ovld2", ov0, 0);
    chk("arst_acc_post", acc0, 0);
    push(1, 4, 5, 1, 1);
    idle(2);
    chk("arst_new_ovld", ov0, 1);
    chk("arst_new_acc", acc0, 20);
    chk("arst_new_cnt", cnt0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
